// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the two-master AXI4 arbiter:
//   - write / read channel FSM state encodings
//   - AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   - AXI burst type codes
// No ports; imported by axi_master_arbiter, rr_arb2 and the bench.
// ----------------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-input picker with a round-robin pointer.
//   clk, reset  : clock, synchronous active-high reset (pointer -> 0)
//   i_req[1:0]  : request vector (bit N = master N)
//   i_advance   : pulse when the owning transaction completes
//   i_served    : index of the master that just completed
//   o_pick      : index of the winner for the current request vector
// FIXED_PRIO=1 ignores the pointer and lets master 0 win every tie.
// ----------------------------------------------------------------------------
module rr_arb2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   input  logic       i_served,
   output logic       o_pick
);

   logic r_ptr;

   // Pointer moves to the master that did not just finish
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= 1'b0;
      end else if (i_advance) begin
         r_ptr <= ~i_served;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   // Winner selection: lone requester wins, ties go to pointer or m0
   always_comb begin
      o_pick = 1'b0;
      case (i_req)
         2'b01:   o_pick = 1'b0;
         2'b10:   o_pick = 1'b1;
         2'b11:   o_pick = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
         default: o_pick = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_master_arbiter.sv
// ----------------------------------------------------------------------------
// axi_master_arbiter
// Two-master to one-slave AXI4 arbiter. Write (AW/W/B) and read (AR/R) are
// arbitrated independently; a grant is held from the address handshake to
// the last response beat. All valid/ready paths are pure muxes.
//   clk, reset          : clock, synchronous active-high reset
//   m0_* / m1_*         : AXI4 slave-side ports for the CPU (m0) and DMA (m1)
//   s_*                 : AXI4 master-side port toward the crossbar
//   wr_grant / rd_grant : index of the master currently or last granted
//   wr_busy  / rd_busy  : channel FSM not idle
// ----------------------------------------------------------------------------
module axi_master_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic                clk,
   input  logic                reset,
   // master 0
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic [7:0]          m0_awlen,
   input  logic [2:0]          m0_awsize,
   input  logic [1:0]          m0_awburst,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wlast,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   output logic [1:0]          m0_bresp,
   output logic                m0_bvalid,
   input  logic                m0_bready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [7:0]          m0_arlen,
   input  logic [2:0]          m0_arsize,
   input  logic [1:0]          m0_arburst,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rlast,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // master 1
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [7:0]          m1_awlen,
   input  logic [2:0]          m1_awsize,
   input  logic [1:0]          m1_awburst,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wlast,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [7:0]          m1_arlen,
   input  logic [2:0]          m1_arsize,
   input  logic [1:0]          m1_arburst,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rlast,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   // crossbar side
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [7:0]          s_awlen,
   output logic [2:0]          s_awsize,
   output logic [1:0]          s_awburst,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wlast,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [7:0]          s_arlen,
   output logic [2:0]          s_arsize,
   output logic [1:0]          s_arburst,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rlast,
   input  logic                s_rvalid,
   output logic                s_rready,
   // status
   output logic                wr_grant,
   output logic                rd_grant,
   output logic                wr_busy,
   output logic                rd_busy
);

   wr_state_e r_wr_state, w_wr_next;
   rd_state_e r_rd_state, w_rd_next;
   logic      r_wr_grant, r_rd_grant;
   logic      w_wr_pick, w_rd_pick;
   logic [1:0] w_aw_req, w_ar_req;
   logic      w_awvalid_sel, w_wvalid_sel, w_wlast_sel, w_bready_sel;
   logic      w_arvalid_sel, w_rready_sel;
   logic      w_aw_hs, w_w_last_hs, w_b_hs, w_ar_hs, w_r_last_hs;

   assign w_aw_req = {m1_awvalid, m0_awvalid};
   assign w_ar_req = {m1_arvalid, m0_arvalid};

   // Selected-master control inputs
   assign w_awvalid_sel = r_wr_grant ? m1_awvalid : m0_awvalid;
   assign w_wvalid_sel  = r_wr_grant ? m1_wvalid  : m0_wvalid;
   assign w_wlast_sel   = r_wr_grant ? m1_wlast   : m0_wlast;
   assign w_bready_sel  = r_wr_grant ? m1_bready  : m0_bready;
   assign w_arvalid_sel = r_rd_grant ? m1_arvalid : m0_arvalid;
   assign w_rready_sel  = r_rd_grant ? m1_rready  : m0_rready;

   assign w_aw_hs     = (r_wr_state == W_ADDR) & w_awvalid_sel & s_awready;
   assign w_w_last_hs = (r_wr_state == W_DATA) & w_wvalid_sel & s_wready & w_wlast_sel;
   assign w_b_hs      = (r_wr_state == W_RESP) & s_bvalid & w_bready_sel;
   assign w_ar_hs     = (r_rd_state == R_ADDR) & w_arvalid_sel & s_arready;
   assign w_r_last_hs = (r_rd_state == R_DATA) & s_rvalid & w_rready_sel & s_rlast;

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_wr_arb (
      .clk(clk), .reset(reset), .i_req(w_aw_req),
      .i_advance(w_b_hs), .i_served(r_wr_grant), .o_pick(w_wr_pick)
   );

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rd_arb (
      .clk(clk), .reset(reset), .i_req(w_ar_req),
      .i_advance(w_r_last_hs), .i_served(r_rd_grant), .o_pick(w_rd_pick)
   );

   // Payload is always muxed from the granted master; responses fan out to both
   assign s_awaddr  = r_wr_grant ? m1_awaddr  : m0_awaddr;
   assign s_awlen   = r_wr_grant ? m1_awlen   : m0_awlen;
   assign s_awsize  = r_wr_grant ? m1_awsize  : m0_awsize;
   assign s_awburst = r_wr_grant ? m1_awburst : m0_awburst;
   assign s_wdata   = r_wr_grant ? m1_wdata   : m0_wdata;
   assign s_wstrb   = r_wr_grant ? m1_wstrb   : m0_wstrb;
   assign s_wlast   = w_wlast_sel;
   assign s_araddr  = r_rd_grant ? m1_araddr  : m0_araddr;
   assign s_arlen   = r_rd_grant ? m1_arlen   : m0_arlen;
   assign s_arsize  = r_rd_grant ? m1_arsize  : m0_arsize;
   assign s_arburst = r_rd_grant ? m1_arburst : m0_arburst;
   assign m0_bresp  = s_bresp;
   assign m1_bresp  = s_bresp;
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m1_rresp  = s_rresp;
   assign m0_rlast  = s_rlast;
   assign m1_rlast  = s_rlast;

   assign wr_grant = r_wr_grant;
   assign rd_grant = r_rd_grant;
   assign wr_busy  = (r_wr_state != W_IDLE);
   assign rd_busy  = (r_rd_state != R_IDLE);

   // State and grant registers; grant is captured only while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
         r_wr_grant <= 1'b0;
         r_rd_grant <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
         r_wr_grant <= ((r_wr_state == W_IDLE) && (|w_aw_req)) ? w_wr_pick : r_wr_grant;
         r_rd_grant <= ((r_rd_state == R_IDLE) && (|w_ar_req)) ? w_rd_pick : r_rd_grant;
      end
   end

   // Next-state logic for both channel FSMs
   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         W_IDLE:  w_wr_next = (|w_aw_req)  ? W_ADDR : W_IDLE;
         W_ADDR:  w_wr_next = w_aw_hs      ? W_DATA : W_ADDR;
         W_DATA:  w_wr_next = w_w_last_hs  ? W_RESP : W_DATA;
         W_RESP:  w_wr_next = w_b_hs       ? W_IDLE : W_RESP;
         default: w_wr_next = W_IDLE;
      endcase
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  w_rd_next = (|w_ar_req)  ? R_ADDR : R_IDLE;
         R_ADDR:  w_rd_next = w_ar_hs      ? R_DATA : R_ADDR;
         R_DATA:  w_rd_next = w_r_last_hs  ? R_IDLE : R_DATA;
         default: w_rd_next = R_IDLE;
      endcase
   end

   // Valid/ready gating: only the owning state passes handshakes, only to master g
   always_comb begin
      s_awvalid  = 1'b0;  s_wvalid   = 1'b0;  s_bready   = 1'b0;
      m0_awready = 1'b0;  m1_awready = 1'b0;
      m0_wready  = 1'b0;  m1_wready  = 1'b0;
      m0_bvalid  = 1'b0;  m1_bvalid  = 1'b0;
      s_arvalid  = 1'b0;  s_rready   = 1'b0;
      m0_arready = 1'b0;  m1_arready = 1'b0;
      m0_rvalid  = 1'b0;  m1_rvalid  = 1'b0;
      case (r_wr_state)
         W_ADDR: begin
            s_awvalid  = w_awvalid_sel;
            m0_awready = s_awready & ~r_wr_grant;
            m1_awready = s_awready &  r_wr_grant;
         end
         W_DATA: begin
            s_wvalid  = w_wvalid_sel;
            m0_wready = s_wready & ~r_wr_grant;
            m1_wready = s_wready &  r_wr_grant;
         end
         W_RESP: begin
            s_bready  = w_bready_sel;
            m0_bvalid = s_bvalid & ~r_wr_grant;
            m1_bvalid = s_bvalid &  r_wr_grant;
         end
         default: s_awvalid = 1'b0;
      endcase
      case (r_rd_state)
         R_ADDR: begin
            s_arvalid  = w_arvalid_sel;
            m0_arready = s_arready & ~r_rd_grant;
            m1_arready = s_arready &  r_rd_grant;
         end
         R_DATA: begin
            s_rready  = w_rready_sel;
            m0_rvalid = s_rvalid & ~r_rd_grant;
            m1_rvalid = s_rvalid &  r_rd_grant;
         end
         default: s_arvalid = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_master_arbiter
// Self-checking bench: two master drivers, a simple always-ready crossbar
// slave, and a negedge scoreboard monitor that pops expected AW/W/AR/R beats.
// ----------------------------------------------------------------------------
module tb_axi_master_arbiter;
   import axi_arb_pkg::*;

   localparam int BOUND = 200;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // master-side drive
   logic [31:0] m_awaddr[2];  logic [7:0] m_awlen[2];  logic [2:0] m_awsize[2];
   logic [1:0]  m_awburst[2]; logic m_awvalid[2];
   logic [31:0] m_wdata[2];   logic [3:0] m_wstrb[2];  logic m_wlast[2]; logic m_wvalid[2];
   logic        m_bready[2];
   logic [31:0] m_araddr[2];  logic [7:0] m_arlen[2];  logic [2:0] m_arsize[2];
   logic [1:0]  m_arburst[2]; logic m_arvalid[2];      logic m_rready[2];

   logic m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
   logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
   logic [1:0] m0_bresp, m1_bresp, m0_rresp, m1_rresp;
   logic [31:0] m0_rdata, m1_rdata;

   // slave side
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [7:0]  s_awlen, s_arlen;
   logic [2:0]  s_awsize, s_arsize;
   logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
   logic [3:0]  s_wstrb;
   logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
   logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic wr_grant, rd_grant, wr_busy, rd_busy;

   logic [1:0]  wr_resp_cfg = AXI_RESP_OKAY;
   logic [1:0]  rd_last_resp_cfg = AXI_RESP_OKAY;
   logic [31:0] sl_rbase;
   logic [7:0]  sl_rlen, sl_rcnt;

   logic [39:0] exp_aw[$];
   logic [32:0] exp_w[$];
   logic [39:0] exp_ar[$];
   logic [34:0] exp_r0[$];
   logic [34:0] exp_r1[$];

   axi_master_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
      .clk(clk), .reset(reset),
      .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]),
      .m0_awburst(m_awburst[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m0_awready),
      .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]),
      .m0_wvalid(m_wvalid[0]), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m_bready[0]),
      .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arsize(m_arsize[0]),
      .m0_arburst(m_arburst[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]),
      .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]),
      .m1_awburst(m_awburst[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m1_awready),
      .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]),
      .m1_wvalid(m_wvalid[1]), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m_bready[1]),
      .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arsize(m_arsize[1]),
      .m1_arburst(m_arburst[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
      .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy), .rd_busy(rd_busy)
   );

   // Crossbar model: AW/W always ready, one B per burst; AR accepted when no R pending
   assign s_awready = 1'b1;
   assign s_wready  = 1'b1;
   assign s_arready = ~s_rvalid;

   always @(posedge clk) begin
      if (reset) begin
         s_bvalid <= 1'b0;
         s_bresp  <= AXI_RESP_OKAY;
      end else if (s_wvalid && s_wready && s_wlast) begin
         s_bvalid <= 1'b1;
         s_bresp  <= wr_resp_cfg;
      end else if (s_bvalid && s_bready) begin
         s_bvalid <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= 32'd0; s_rresp <= AXI_RESP_OKAY;
         sl_rcnt  <= 8'd0; sl_rlen <= 8'd0; sl_rbase <= 32'd0;
      end else if (s_arvalid && s_arready) begin
         s_rvalid <= 1'b1; s_rdata <= s_araddr; s_rlast <= (s_arlen == 8'd0);
         s_rresp  <= (s_arlen == 8'd0) ? rd_last_resp_cfg : AXI_RESP_OKAY;
         sl_rcnt  <= 8'd0; sl_rlen <= s_arlen; sl_rbase <= s_araddr;
      end else if (s_rvalid && s_rready) begin
         if (s_rlast) begin
            s_rvalid <= 1'b0; s_rlast <= 1'b0;
         end else begin
            sl_rcnt <= sl_rcnt + 8'd1;
            s_rdata <= sl_rbase + 32'(sl_rcnt) + 32'd1;
            s_rlast <= ((sl_rcnt + 8'd1) == sl_rlen);
            s_rresp <= ((sl_rcnt + 8'd1) == sl_rlen) ? rd_last_resp_cfg : AXI_RESP_OKAY;
         end
      end
   end

   // Scoreboard monitor: every handshake pops and compares one expected item
   initial begin
      logic [39:0] e40;
      logic [32:0] e33;
      logic [34:0] e35;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (s_awvalid && s_awready) begin
               checks++;
               e40 = (exp_aw.size() > 0) ? exp_aw.pop_front() : 40'hx;
               if ({s_awaddr, s_awlen} !== e40) begin
                  errors++; $display("FAIL aw got=%h want=%h", {s_awaddr, s_awlen}, e40);
               end
            end
            if (s_wvalid && s_wready) begin
               checks++;
               e33 = (exp_w.size() > 0) ? exp_w.pop_front() : 33'hx;
               if ({s_wdata, s_wlast} !== e33) begin
                  errors++; $display("FAIL w got=%h want=%h", {s_wdata, s_wlast}, e33);
               end
            end
            if (s_arvalid && s_arready) begin
               checks++;
               e40 = (exp_ar.size() > 0) ? exp_ar.pop_front() : 40'hx;
               if ({s_araddr, s_arlen} !== e40) begin
                  errors++; $display("FAIL ar got=%h want=%h", {s_araddr, s_arlen}, e40);
               end
            end
            if (m0_rvalid && m_rready[0]) begin
               checks++;
               e35 = (exp_r0.size() > 0) ? exp_r0.pop_front() : 35'hx;
               if ({m0_rdata, m0_rresp, m0_rlast} !== e35) begin
                  errors++; $display("FAIL r_m0 got=%h want=%h", {m0_rdata, m0_rresp, m0_rlast}, e35);
               end
            end
            if (m1_rvalid && m_rready[1]) begin
               checks++;
               e35 = (exp_r1.size() > 0) ? exp_r1.pop_front() : 35'hx;
               if ({m1_rdata, m1_rresp, m1_rlast} !== e35) begin
                  errors++; $display("FAIL r_m1 got=%h want=%h", {m1_rdata, m1_rresp, m1_rlast}, e35);
               end
            end
         end
      end
   end

   function automatic logic [18:0] outs_vec();
      return {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready, m0_awready, m1_awready,
              m0_wready, m1_wready, m0_bvalid, m1_bvalid, m0_arready, m1_arready,
              m0_rvalid, m1_rvalid, wr_grant, rd_grant, wr_busy, rd_busy};
   endfunction

   function automatic logic aw_rdy(input int m); return (m == 0) ? m0_awready : m1_awready; endfunction
   function automatic logic w_rdy(input int m);  return (m == 0) ? m0_wready  : m1_wready;  endfunction
   function automatic logic b_vld(input int m);  return (m == 0) ? m0_bvalid  : m1_bvalid;  endfunction
   function automatic logic [1:0] b_rsp(input int m); return (m == 0) ? m0_bresp : m1_bresp; endfunction
   function automatic logic ar_rdy(input int m); return (m == 0) ? m0_arready : m1_arready; endfunction
   function automatic logic r_vld(input int m);  return (m == 0) ? m0_rvalid  : m1_rvalid;  endfunction
   function automatic logic r_lst(input int m);  return (m == 0) ? m0_rlast   : m1_rlast;   endfunction

   task automatic push_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base);
      exp_aw.push_back({addr, len});
      for (int i = 0; i <= int'(len); i++) exp_w.push_back({base + 32'(i), (i == int'(len))});
   endtask

   task automatic push_read(input int m, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] last_resp);
      exp_ar.push_back({addr, len});
      for (int i = 0; i <= int'(len); i++) begin
         if (m == 0) exp_r0.push_back({addr + 32'(i), (i == int'(len)) ? last_resp : AXI_RESP_OKAY, (i == int'(len))});
         else        exp_r1.push_back({addr + 32'(i), (i == int'(len)) ? last_resp : AXI_RESP_OKAY, (i == int'(len))});
      end
   endtask

   // Master write: W beat 0 is presented together with AW (W-before-AW)
   task automatic m_write(input int m, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input logic [1:0] exp_resp);
      int n;
      m_awaddr[m] = addr; m_awlen[m] = len; m_awsize[m] = 3'd2; m_awburst[m] = AXI_BURST_INCR;
      m_awvalid[m] = 1'b1;
      m_wdata[m] = base; m_wstrb[m] = 4'hF; m_wlast[m] = (len == 8'd0); m_wvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!aw_rdy(m) && n < BOUND);
      if (!aw_rdy(m)) begin checks++; errors++; $display("FAIL aw_timeout m%0d got=0 want=1", m); end
      @(posedge clk); #1; m_awvalid[m] = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         m_wdata[m] = base + 32'(i); m_wlast[m] = (i == int'(len)); m_wvalid[m] = 1'b1;
         n = 0;
         while (n < BOUND) begin @(negedge clk); n++; if (w_rdy(m)) break; end
         if (!w_rdy(m)) begin checks++; errors++; $display("FAIL w_timeout m%0d got=0 want=1", m); end
         @(posedge clk); #1;
      end
      m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; m_bready[m] = 1'b1;
      n = 0;
      while (n < BOUND) begin @(negedge clk); n++; if (b_vld(m)) break; end
      checks++;
      if (!b_vld(m) || b_rsp(m) !== exp_resp) begin
         errors++; $display("FAIL bresp m%0d got=%b/%b want=1/%b", m, b_vld(m), b_rsp(m), exp_resp);
      end
      @(posedge clk); #1; m_bready[m] = 1'b0;
   endtask

   task automatic m_read(input int m, input logic [31:0] addr, input logic [7:0] len, input bit toggle);
      int n;
      bit done;
      m_araddr[m] = addr; m_arlen[m] = len; m_arsize[m] = 3'd2; m_arburst[m] = AXI_BURST_INCR;
      m_arvalid[m] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!ar_rdy(m) && n < BOUND);
      if (!ar_rdy(m)) begin checks++; errors++; $display("FAIL ar_timeout m%0d got=0 want=1", m); end
      @(posedge clk); #1; m_arvalid[m] = 1'b0; m_rready[m] = 1'b1;
      done = 1'b0; n = 0;
      while (!done && n < BOUND) begin
         @(negedge clk); n++;
         if (r_vld(m) && m_rready[m] && r_lst(m)) done = 1'b1;
         @(posedge clk); #1;
         if (toggle) m_rready[m] = ~m_rready[m];
      end
      m_rready[m] = 1'b0;
      if (!done) begin checks++; errors++; $display("FAIL rlast_timeout m%0d got=0 want=1", m); end
   endtask

   task automatic test_reset();
      m_awvalid[0] = 1'b1; m_arvalid[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs_vec() !== 19'd0) begin errors++; $display("FAIL reset_outputs got=%b want=0", outs_vec()); end
      @(posedge clk); #1;
      m_awvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_arbitration();
      bit m0_done = 1'b0;
      bit seen = 1'b0;
      push_write(32'h0000_1000, 8'd3, 32'h0000_00A0);
      push_write(32'h0000_2000, 8'd3, 32'h0000_00B0);
      fork
         begin m_write(0, 32'h0000_1000, 8'd3, 32'h0000_00A0, AXI_RESP_OKAY); m0_done = 1'b1; end
         m_write(1, 32'h0000_2000, 8'd3, 32'h0000_00B0, AXI_RESP_OKAY);
         begin
            for (int n = 0; n < BOUND && !m0_done; n++) begin
               @(negedge clk);
               if (m1_wready || m1_awready) seen = 1'b1;
            end
         end
      join
      checks++;
      if (seen) begin errors++; $display("FAIL m1_held_during_m0 got=1 want=0"); end
   endtask

   task automatic test_single_write();
      push_write(32'h4000_0004, 8'd0, 32'h0000_0041);
      m_write(0, 32'h4000_0004, 8'd0, 32'h0000_0041, AXI_RESP_OKAY);
      @(negedge clk);
      checks++;
      if (wr_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_idle got=%b want=0", wr_busy); end
      @(posedge clk); #1;
      wr_resp_cfg = AXI_RESP_DECERR;
      push_write(32'h0000_0100, 8'd1, 32'h0000_0050);
      m_write(1, 32'h0000_0100, 8'd1, 32'h0000_0050, AXI_RESP_DECERR);
      wr_resp_cfg = AXI_RESP_OKAY;
   endtask

   task automatic test_concurrent();
      bit wd = 1'b0, rdn = 1'b0, m0_rv = 1'b0, both = 1'b0;
      push_write(32'h0000_3000, 8'd3, 32'h0000_00C0);
      push_read(1, 32'h0000_0010, 8'd7, AXI_RESP_OKAY);
      fork
         begin m_write(0, 32'h0000_3000, 8'd3, 32'h0000_00C0, AXI_RESP_OKAY); wd = 1'b1; end
         begin m_read(1, 32'h0000_0010, 8'd7, 1'b0); rdn = 1'b1; end
         begin
            for (int n = 0; n < BOUND && !(wd && rdn); n++) begin
               @(negedge clk);
               if (m0_rvalid) m0_rv = 1'b1;
               if (wr_busy && rd_busy && !wr_grant && rd_grant) both = 1'b1;
            end
         end
      join
      checks++;
      if (m0_rv) begin errors++; $display("FAIL m0_rvalid_quiet got=1 want=0"); end
      checks++;
      if (!both) begin errors++; $display("FAIL concurrent_owners got=0 want=1"); end
   endtask

   task automatic test_rresp_error();
      rd_last_resp_cfg = AXI_RESP_SLVERR;
      push_read(0, 32'h0000_0020, 8'd1, AXI_RESP_SLVERR);
      m_read(0, 32'h0000_0020, 8'd1, 1'b0);
      rd_last_resp_cfg = AXI_RESP_OKAY;
      @(negedge clk);
      checks++;
      if (rd_busy !== 1'b0) begin errors++; $display("FAIL rd_idle_after_err got=%b want=0", rd_busy); end
      @(posedge clk); #1;
      push_read(0, 32'h0000_0030, 8'd0, AXI_RESP_OKAY);
      m_read(0, 32'h0000_0030, 8'd0, 1'b0);
   endtask

   task automatic test_backpressure();
      bit rdn = 1'b0, bad = 1'b0;
      push_read(0, 32'h0000_0000, 8'd7, AXI_RESP_OKAY);
      fork
         begin m_read(0, 32'h0000_0000, 8'd7, 1'b1); rdn = 1'b1; end
         begin
            for (int n = 0; n < BOUND && !rdn; n++) begin
               @(negedge clk);
               if (rd_busy && (s_rready !== m_rready[0])) bad = 1'b1;
            end
         end
      join
      checks++;
      if (bad) begin errors++; $display("FAIL s_rready_mirror got=1 want=0"); end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      exp_aw.push_back({32'h5000_0000, 8'd3});
      exp_w.push_back({32'h0000_00D0, 1'b0});
      exp_w.push_back({32'h0000_00D1, 1'b0});
      m_awaddr[0] = 32'h5000_0000; m_awlen[0] = 8'd3; m_awvalid[0] = 1'b1;
      m_wdata[0] = 32'h0000_00D0; m_wlast[0] = 1'b0; m_wvalid[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!m0_awready && n < BOUND);
      @(posedge clk); #1; m_awvalid[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_wdata[0] = 32'h0000_00D0 + 32'(i);
         n = 0;
         do begin @(negedge clk); n++; end while (!m0_wready && n < BOUND);
         @(posedge clk); #1;
      end
      m_wdata[0] = 32'h0000_00D2;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs_vec() !== 19'd0) begin errors++; $display("FAIL reset_mid_burst got=%b want=0", outs_vec()); end
      @(posedge clk); #1;
      reset = 1'b0; m_wvalid[0] = 1'b0;
      push_write(32'h6000_0000, 8'd0, 32'h0000_00E1);
      fork
         m_write(1, 32'h6000_0000, 8'd0, 32'h0000_00E1, AXI_RESP_OKAY);
         begin
            @(negedge clk);
            checks++;
            if (wr_busy !== 1'b0) begin errors++; $display("FAIL arb_latency got=%b want=0", wr_busy); end
            @(negedge clk);
            checks++;
            if ({wr_busy, wr_grant} !== 2'b11) begin
               errors++; $display("FAIL grant_after_reset got=%b want=11", {wr_busy, wr_grant});
            end
         end
      join
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_awaddr[m] = 32'd0; m_awlen[m] = 8'd0; m_awsize[m] = 3'd2; m_awburst[m] = AXI_BURST_INCR;
         m_awvalid[m] = 1'b0; m_wdata[m] = 32'd0; m_wstrb[m] = 4'hF; m_wlast[m] = 1'b0;
         m_wvalid[m] = 1'b0; m_bready[m] = 1'b0; m_araddr[m] = 32'd0; m_arlen[m] = 8'd0;
         m_arsize[m] = 3'd2; m_arburst[m] = AXI_BURST_INCR; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
      end
      test_reset();
      test_arbitration();
      test_single_write();
      test_concurrent();
      test_rresp_error();
      test_backpressure();
      test_reset_mid_burst();
      repeat (2) @(posedge clk);
      checks++;
      if (exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r0.size() + exp_r1.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d/%0d/%0d/%0d/%0d want=0", exp_aw.size(),
                  exp_w.size(), exp_ar.size(), exp_r0.size(), exp_r1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_master_arbiter.md
Name: axi_master_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter in front of the crossbar's single master port.
- Lets a second initiator share the crossbar with the VexRiscv master: CPU on m0; DMA or debug loader on m1, e.g. for boot-RAM preload over UART.
- Write channel (AW/W/B) and read channel (AR/R) are arbitrated independently and concurrently.
- A grant is held for a whole transaction, address through last response beat.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width is DATA_W/8)
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins a tie

Ports:
All ports are driven and sampled on the rising edge of clk.

clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mN_awaddr/awlen/awsize/awburst/awvalid  in  ADDR_W/8/3/2/1  master N write address (N = 0, 1)
mN_awready  out  1  write address accept to master N
mN_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  master N write data
mN_wready  out  1  write data accept to master N
mN_bresp/bvalid  out  2/1  write response to master N
mN_bready  in  1  master N response accept
mN_araddr/arlen/arsize/arburst/arvalid  in  ADDR_W/8/3/2/1  master N read address
mN_arready  out  1  read address accept to master N
mN_rdata/rresp/rlast/rvalid  out  DATA_W/2/1/1  read data to master N
mN_rready  in  1  master N read data accept
s_aw*/s_w*/s_ar*  out  as above  mirrored request channels to the crossbar master port
s_awready/s_wready/s_bresp/s_bvalid/s_arready/s_rdata/s_rresp/s_rlast/s_rvalid  in  as above  crossbar responses
s_bready/s_rready  out  1  response accept to the crossbar
wr_grant, rd_grant  out  1  index of the master currently or last granted
wr_busy, rd_busy  out  1  channel FSM not idle

Behaviour:
- Reset, synchronous: both FSMs go to IDLE and both RR pointers to 0, so m0 is preferred first.
  - All valid and ready outputs are 0.
  - wr_grant = rd_grant = 0 and busy = 0.
  - Reset mid-burst abandons the transaction; outputs go low at the same edge. Crossbar recovery is handled by the shared reset.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: if any mN_awvalid, register the winner into wr_grant and go to W_ADDR. This is one cycle of arbitration latency.
  - W_ADDR: s_awvalid = m[g]_awvalid and m[g]_awready = s_awready. On the handshake go to W_DATA.
  - W_DATA: W channel is passed through for master g. On s_wvalid & s_wready & s_wlast go to W_RESP.
  - W_RESP: B is routed to master g. On bvalid & bready go to W_IDLE and update the pointer.
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - Arbitration and the AR handshake work the same as on the write side.
  - R_DATA: R is routed to master g and leaves on rvalid & rready & rlast.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, FIXED_PRIO = 0: the master the pointer selects wins, and after completion the pointer points to the other master.
  - Both requesting, FIXED_PRIO = 1: m0 wins.
- Gating:
  - The non-granted master sees awready, wready, bvalid, arready and rvalid all at 0.
  - Outside the owning state, every s_*valid and s_*ready output is 0.
  - Payload outputs are always muxed from the granted master, never X.
- W arriving before AW is legal. W is held (wready = 0) until the AW handshake; masters must not gate AW on wready.
- Read and write may be owned by different masters at the same time.
- bresp and rresp pass through unmodified, including SLVERR and DECERR. The block never generates responses.
- Combinational paths are mux-only: ready and valid pass through in a single cycle with no registered skid. Throughput is one beat per cycle.
- A request that drops valid before its handshake is an AXI violation. Behaviour in that case is unspecified, but the FSM must not deadlock; it waits in ADDR.

Decomposition:
- Package axi_arb_pkg holds:
  - write and read state enums
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - burst type constants
- Sub-module rr_arb2: 2-input round-robin picker with the pointer register, advance strobe and FIXED_PRIO. It is instantiated once for write and once for read.
- The remaining logic is the FSMs plus channel muxes.

Test Plan:
- Single write, m0, awaddr=0x4000_0004, len=0, wdata=0x41 -> s_awaddr matches; one W beat with wlast; m0 gets bresp=0 one cycle after s_bvalid handshake clears; wr_busy returns to 0.
- Simultaneous awvalid from m0 and m1 (len=3 each), FIXED_PRIO=0 -> m0 served first with 4 beats; then m1 with 4 beats; m1 sees wready=0 throughout m0's burst.
- Concurrent read by m1 (araddr=0x0000_0010, len=7) during m0 write -> 8 R beats delivered to m1 with rlast on beat 8; m0 write completes independently; m0_rvalid stays 0.
- Slave returns rresp=2'b10 on the beat with rlast -> m0 sees rresp=2'b10; FSM returns to R_IDLE; next request is accepted.
- Backpressure: m0_rready toggles every cycle -> s_rready mirrors it; no beat is lost or duplicated (check data sequence 0..7).
- Reset asserted on beat 2 of a 4-beat write -> next edge: all valid/ready = 0, wr_busy = 0, pointer = 0; a fresh m1 request is granted two cycles after reset deasserts.
